multi_dev_bridge: RTL

//   Processor-to-peripheral system bridge for NDEV memory-mapped devices. Decodes the CPU address

---
 rtl/bridge_pkg.sv | 28 ++
 rtl/bridge_irq_ctrl.sv | 55 +++++
 rtl/multi_dev_bridge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the multi-device bridge.
//   brgState_t   : bridge FSM states
//   REG_*        : byte offsets of the bridge registers inside the 16-byte window
//   ERR_IRQ_BIT  : oINTRQ bit that reports a captured error
//   IRQ_W        : width of the interrupt output / mask register
//   winHit()     : base/mask window decode helper
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } brgState_t;

  localparam logic [3:0] REG_MASK = 4'h0;
  localparam logic [3:0] REG_PEND = 4'h4;
  localparam logic [3:0] REG_ERR  = 4'h8;

  localparam int ERR_IRQ_BIT = 5;
  localparam int IRQ_W       = 6;

  function automatic logic winHit(input logic [31:0] addr,
                                  input logic [31:0] base,
                                  input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/bridge_irq_ctrl.sv
// Interrupt pending/mask block of the bridge.
// Ports:
//   iCLK, iRST_N  clock, async active-low reset
//   iIntrq        device interrupt levels (synchronous to iCLK)
//   iMaskWr       load iMaskData into the mask register
//   iPendW1c      clear the pending bits that are 1 in iW1cData
//   iErrValid     captured-error flag from the bridge
//   oMask         mask register
//   oPend         pending register
//   oIntrq        [NDEV-1:0] pend & mask, [ERR_IRQ_BIT] err & mask, other bits 0
module bridge_irq_ctrl
  import bridge_pkg::*;
#(
  parameter int NDEV = 2
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [NDEV-1:0]  iIntrq,
  input  logic             iMaskWr,
  input  logic [IRQ_W-1:0] iMaskData,
  input  logic             iPendW1c,
  input  logic [NDEV-1:0]  iW1cData,
  input  logic             iErrValid,
  output logic [IRQ_W-1:0] oMask,
  output logic [NDEV-1:0]  oPend,
  output logic [IRQ_W-1:0] oIntrq
);

  logic [NDEV-1:0] intrqPrev;
  logic [NDEV-1:0] rise;
  logic [NDEV-1:0] clr;

  assign rise = iIntrq & ~intrqPrev;
  assign clr  = iPendW1c ? iW1cData : '0;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      intrqPrev <= '0;
      oMask     <= '0;
      oPend     <= '0;
    end else begin
      intrqPrev <= iIntrq;
      if (iMaskWr) oMask <= iMaskData;
      // A new edge wins over a W1C hitting the same bit in the same cycle.
      oPend <= (oPend & ~clr) | rise;
    end
  end

  always_comb begin
    oIntrq              = '0;
    oIntrq[NDEV-1:0]    = oPend & oMask[NDEV-1:0];
    oIntrq[ERR_IRQ_BIT] = iErrValid & oMask[ERR_IRQ_BIT];
  end

endmodule

// File: rtl/multi_dev_bridge.sv
// CPU-to-peripheral bridge for NDEV memory-mapped devices.
// Decodes the CPU address against per-device base/mask windows, runs the
// device access with an ack timeout, and serves a 16-byte register window
// (MASK, PEND, ERR) for interrupt and error state.
// Ports:
//   iCLK, iRST_N                 clock, async active-low reset
//   iPR_Req/WE/Addr/Data/BE      CPU request (sampled in IDLE only)
//   oPR_Ready/Data/Err           one-cycle CPU response
//   oDEV_Sel/WE/Addr/Data/BE     device access, held through ACCESS
//   iDEV_Ack, iDEV_Data          per-device completion and read data
//   iINTRQ, oINTRQ               device interrupt levels in, masked interrupts out
//
// state  | meaning
// IDLE   | waiting for iPR_Req; decode and register ops happen here
// ACCESS | device selected, timer running, waiting for ack
// RESP   | oPR_Ready pulse with latched data/err
module multi_dev_bridge
  import bridge_pkg::*;
#(
  parameter int                 NDEV      = 2,
  parameter logic [NDEV*32-1:0] DEV_BASE  = {32'h0000_7F10, 32'h0000_7F00},
  parameter logic [NDEV*32-1:0] DEV_MASK  = {NDEV{32'hFFFF_FFF0}},
  parameter logic [31:0]        BRG_BASE  = 32'h0000_7F20,
  parameter int                 TIMEOUT   = 15,
  parameter bit                 WORD_ONLY = 1'b1
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iPR_Req,
  input  logic                 iPR_WE,
  input  logic [31:0]          iPR_Addr,
  input  logic [31:0]          iPR_Data,
  input  logic [3:0]           iPR_BE,
  output logic                 oPR_Ready,
  output logic [31:0]          oPR_Data,
  output logic                 oPR_Err,
  output logic [NDEV-1:0]      oDEV_Sel,
  output logic                 oDEV_WE,
  output logic [29:0]          oDEV_Addr,
  output logic [31:0]          oDEV_Data,
  output logic [3:0]           oDEV_BE,
  input  logic [NDEV-1:0]      iDEV_Ack,
  input  logic [NDEV*32-1:0]   iDEV_Data,
  input  logic [NDEV-1:0]      iINTRQ,
  output logic [IRQ_W-1:0]     oINTRQ
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  brgState_t       state, stateNxt;

  logic [NDEV-1:0] selLat;
  logic            weLat;
  logic [31:0]     addrLat;
  logic [31:0]     dataLat;
  logic [3:0]      beLat;
  logic [TW-1:0]   timer;
  logic [31:0]     respData;
  logic            respErr;
  logic            errValid;
  logic [30:0]     errAddr;

  logic            accept;
  logic            brgHit;
  logic [NDEV-1:0] devHit;
  logic            anyHit;
  logic            woErr;
  logic            idleErr;
  logic [3:0]      regOff;
  logic [31:0]     regRdData;
  logic            regErr;
  logic            maskWr;
  logic            pendW1c;
  logic            errClr;
  logic            ackHit;
  logic [31:0]     ackData;
  logic            timerDone;
  logic            accessErr;

  logic [IRQ_W-1:0] mask;
  logic [NDEV-1:0]  pend;

  // ---------------- decode ----------------
  assign accept = (state == IDLE) && iPR_Req;
  assign brgHit = iPR_Addr[31:4] == BRG_BASE[31:4];
  assign regOff = {iPR_Addr[3:2], 2'b00};
  assign woErr  = WORD_ONLY && iPR_WE && (iPR_BE != 4'hF);

  // Lowest-index window wins when device windows overlap.
  always_comb begin
    devHit = '0;
    anyHit = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      if (!anyHit && winHit(iPR_Addr, DEV_BASE[i*32 +: 32], DEV_MASK[i*32 +: 32])) begin
        devHit[i] = 1'b1;
        anyHit    = 1'b1;
      end
    end
  end

  // ---------------- bridge register window ----------------
  always_comb begin
    regRdData = '0;
    regErr    = 1'b0;
    maskWr    = 1'b0;
    pendW1c   = 1'b0;
    errClr    = 1'b0;
    if (accept && brgHit) begin
      if (iPR_WE) begin
        if (iPR_BE != 4'hF) begin
          regErr = 1'b1;
        end else begin
          case (regOff)
            REG_MASK: maskWr  = 1'b1;
            REG_PEND: pendW1c = 1'b1;
            REG_ERR:  errClr  = 1'b1;
            default:  regErr  = 1'b1;
          endcase
        end
      end else begin
        case (regOff)
          REG_MASK: regRdData[IRQ_W-1:0] = mask;
          REG_PEND: regRdData[NDEV-1:0]  = pend;
          REG_ERR:  regRdData            = {errValid, errAddr};
          default:  regRdData            = '0;
        endcase
      end
    end
  end

  assign idleErr = accept && (brgHit ? regErr : (anyHit ? woErr : 1'b1));

  // ---------------- device side ----------------
  assign ackHit    = |(iDEV_Ack & selLat);
  assign timerDone = timer == TIMER_LAST;
  assign accessErr = (state == ACCESS) && !ackHit && timerDone;

  always_comb begin
    ackData = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (selLat[i]) ackData = ackData | iDEV_Data[i*32 +: 32];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (iPR_Req) begin
          if (!brgHit && anyHit && !woErr) stateNxt = ACCESS;
          else                             stateNxt = RESP;
        end
      end
      ACCESS: begin
        if (ackHit || timerDone) stateNxt = RESP;
      end
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      selLat   <= '0;
      weLat    <= 1'b0;
      addrLat  <= '0;
      dataLat  <= '0;
      beLat    <= '0;
      timer    <= '0;
      respData <= '0;
      respErr  <= 1'b0;
      errValid <= 1'b0;
      errAddr  <= '0;
    end else begin
      if (accept) begin
        selLat   <= devHit;
        weLat    <= iPR_WE;
        addrLat  <= iPR_Addr;
        dataLat  <= iPR_Data;
        beLat    <= iPR_BE;
        timer    <= '0;
        respData <= regRdData;
        respErr  <= idleErr;
      end else if (state == ACCESS) begin
        if (ackHit) begin
          respData <= weLat ? 32'h0 : ackData;
          respErr  <= 1'b0;
          timer    <= '0;
        end else if (timerDone) begin
          respData <= '0;
          respErr  <= 1'b1;
          timer    <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end

      // Latest error overwrites the previous capture.
      if (idleErr) begin
        errValid <= 1'b1;
        errAddr  <= iPR_Addr[30:0];
      end else if (accessErr) begin
        errValid <= 1'b1;
        errAddr  <= addrLat[30:0];
      end else if (errClr) begin
        errValid <= 1'b0;
      end
    end
  end

  // ---------------- outputs ----------------
  assign oPR_Ready = state == RESP;
  assign oPR_Data  = oPR_Ready ? respData : 32'h0;
  assign oPR_Err   = oPR_Ready & respErr;
  assign oDEV_Sel  = (state == ACCESS) ? selLat : '0;
  assign oDEV_WE   = (state == ACCESS) & weLat;
  assign oDEV_Addr = addrLat[31:2];
  assign oDEV_Data = dataLat;
  assign oDEV_BE   = beLat;

  bridge_irq_ctrl #(
    .NDEV (NDEV)
  ) uIrq (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iIntrq    (iINTRQ),
    .iMaskWr   (maskWr),
    .iMaskData (iPR_Data[IRQ_W-1:0]),
    .iPendW1c  (pendW1c),
    .iW1cData  (iPR_Data[NDEV-1:0]),
    .iErrValid (errValid),
    .oMask     (mask),
    .oPend     (pend),
    .oIntrq    (oINTRQ)
  );

endmodule
